// File: rtl/acc_uart_streamer.sv
// Pulls bytes from the capture storage block and serialises them as 8N1 UART
// frames, gated by host clear-to-send at each byte start.
module acc_uart_streamer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        ReadClock,
  input  logic        Reset,
  input  logic [7:0]  DataIn,
  input  logic        DataReady,
  input  logic        Cts,
  output logic        ReadEnable,
  output logic        TxD,
  output logic        Busy,
  output logic [15:0] BytesSent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_BIT = 2'd1;
  localparam logic [1:0] DATA_BITS = 2'd2;
  localparam logic [1:0] STOP_BIT  = 2'd3;

  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [15:0]       bytes_sent;
  logic              read_pulse;
  logic              baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // NOTE: every register in this block is written with <= so all of them
  // update together from pre-edge values; a blocking = here would let later
  // statements see half-updated state and break the cycle timing.
  always_ff @(posedge ReadClock) begin
    if (Reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      bytes_sent <= '0;
      read_pulse <= 1'b0;
    end else begin
      read_pulse <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          // Byte is captured on the same edge the pulse is raised, so the
          // storage block may advance freely afterwards.
          if (DataReady && Cts) begin
            shift      <= DataIn;
            read_pulse <= 1'b1;
            state      <= START_BIT;
          end
        end
        START_BIT: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA_BITS: begin
          if (baud_done) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP_BIT;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (baud_done) begin
            baud_cnt   <= '0;
            bytes_sent <= bytes_sent + 16'd1;
            state      <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: TxD gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    TxD = 1'b1;
    case (state)
      START_BIT: TxD = 1'b0;
      DATA_BITS: TxD = shift[0];
      default:   TxD = 1'b1;
    endcase
  end

  assign Busy       = (state != IDLE);
  assign ReadEnable = read_pulse;
  assign BytesSent  = bytes_sent;

endmodule

// File: tb/tb_acc_uart_streamer.sv
// Directed bench for acc_uart_streamer: frame-by-frame TxD checks from a vector
// table plus hand sequences for CTS gating, mid-byte reset and counter wrap.
module tb_acc_uart_streamer;

  localparam int C = 4;

  logic        ReadClock = 1'b0;
  logic        Reset;
  logic [7:0]  DataIn;
  logic        DataReady;
  logic        Cts;
  logic        ReadEnable;
  logic        TxD;
  logic        Busy;
  logic [15:0] BytesSent;

  int checks   = 0;
  int errors   = 0;
  int re_count = 0;
  int last_wait;

  acc_uart_streamer #(.CLKS_PER_BIT(C)) dut (
    .ReadClock (ReadClock),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .DataReady (DataReady),
    .Cts       (Cts),
    .ReadEnable(ReadEnable),
    .TxD       (TxD),
    .Busy      (Busy),
    .BytesSent (BytesSent)
  );

  always #5 ReadClock = ~ReadClock;

  always @(negedge ReadClock) if (ReadEnable === 1'b1) re_count++;

  typedef struct {
    logic [7:0]  data;
    logic [9:0]  frame;      // bit i = i-th bit on the line (start first)
    logic [7:0]  next_data;
    logic        next_ready;
    logic [15:0] count;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for a ReadEnable pulse sampled on a falling edge.
  task automatic wait_pulse(input string name, output bit ok);
    int waited = 0;
    @(negedge ReadClock);
    while (ReadEnable !== 1'b1 && waited < 200) begin
      waited++;
      @(negedge ReadClock);
    end
    last_wait = waited;
    ok = (ReadEnable === 1'b1);
    if (!ok) check({name, " pulse timeout"}, 32'(ReadEnable), 32'd1);
  endtask

  task automatic send_byte(input string name, input logic [7:0] d, input logic [9:0] frame,
                           input logic [7:0] next_d, input logic next_ready,
                           input int cts_drop_n, input logic [15:0] exp_count);
    bit ok;
    int frame_bad = 0, busy_bad = 0, re_bad = 0;
    logic [7:0] got = '0;
    DataIn    = d;
    DataReady = 1'b1;
    wait_pulse(name, ok);
    if (!ok) return;
    for (int n = 0; n < 10 * C; n++) begin
      if (n == 2) begin
        DataIn    = next_d;
        DataReady = next_ready;
      end
      if (n == cts_drop_n) Cts = 1'b0;
      if (TxD !== frame[n / C]) frame_bad++;
      if (Busy !== 1'b1) busy_bad++;
      if (n >= 1 && ReadEnable !== 1'b0) re_bad++;
      if ((n % C) == C / 2 && n / C >= 1 && n / C <= 8) got[n / C - 1] = TxD;
      @(negedge ReadClock);
    end
    check({name, " frame"}, 32'(frame_bad), 32'd0);
    check({name, " busy"}, 32'(busy_bad), 32'd0);
    check({name, " single pulse"}, 32'(re_bad), 32'd0);
    check({name, " decoded"}, 32'(got), 32'(d));
    check({name, " count"}, 32'(BytesSent), 32'(exp_count));
    check({name, " idle"}, 32'({Busy, TxD}), 32'b01);
  endtask

  initial begin
    bit ok;
    int base, bad;

    vecs[0] = '{data: 8'h80, frame: 10'h300, next_data: 8'h02, next_ready: 1'b1, count: 16'd1};
    vecs[1] = '{data: 8'h02, frame: 10'h204, next_data: 8'hA5, next_ready: 1'b1, count: 16'd2};
    vecs[2] = '{data: 8'hA5, frame: 10'h34A, next_data: 8'h3C, next_ready: 1'b1, count: 16'd3};
    vecs[3] = '{data: 8'h3C, frame: 10'h278, next_data: 8'h96, next_ready: 1'b0, count: 16'd4};

    Reset = 1'b1; DataReady = 1'b0; Cts = 1'b0; DataIn = 8'h00;
    repeat (3) @(negedge ReadClock);
    check("reset outputs", 32'({ReadEnable, TxD, Busy}), 32'b010);
    check("reset count", 32'(BytesSent), 32'd0);
    Reset = 1'b0;
    Cts   = 1'b1;
    @(negedge ReadClock);

    // Back-to-back stream, each next byte presented 2 cycles after the pulse.
    base = re_count;
    for (int i = 0; i < 4; i++) begin
      send_byte($sformatf("seq%0d", i), vecs[i].data, vecs[i].frame,
                vecs[i].next_data, vecs[i].next_ready, -1, vecs[i].count);
      check($sformatf("seq%0d latency", i), 32'(last_wait), 32'd0);
    end
    check("seq pulses", 32'(re_count - base), 32'd4);

    // CTS low holds off transmission even with data available.
    Cts = 1'b0; DataReady = 1'b1; DataIn = 8'h96;
    base = re_count; bad = 0;
    repeat (100) begin
      @(negedge ReadClock);
      if ({ReadEnable, TxD, Busy} !== 3'b010) bad++;
    end
    check("cts low hold", 32'(bad), 32'd0);
    check("cts low pulses", 32'(re_count - base), 32'd0);

    // CTS returns: start on the next edge, then drop CTS during data bit 2.
    Cts = 1'b1;
    send_byte("cts drop", 8'h96, 10'h32C, 8'h11, 1'b1, 3 * C + 1, 16'd5);
    check("cts resume latency", 32'(last_wait), 32'd0);
    base = re_count; bad = 0;
    repeat (20) begin
      @(negedge ReadClock);
      if ({ReadEnable, TxD, Busy} !== 3'b010) bad++;
    end
    check("cts gap idle", 32'(bad), 32'd0);
    check("cts gap pulses", 32'(re_count - base), 32'd0);
    Cts = 1'b1;
    send_byte("after cts", 8'h11, 10'h222, 8'h00, 1'b0, -1, 16'd6);
    check("after cts latency", 32'(last_wait), 32'd0);

    // Reset during data bit 5 discards the partial byte; the next byte follows.
    DataIn = 8'h5A; DataReady = 1'b1;
    wait_pulse("reset byte", ok);
    if (ok) begin
      for (int n = 0; n < 6 * C + 1; n++) begin
        if (n == 2) DataIn = 8'hC3;
        @(negedge ReadClock);
      end
      Reset = 1'b1;
      @(negedge ReadClock);
      check("mid reset outputs", 32'({ReadEnable, TxD, Busy}), 32'b010);
      check("mid reset count", 32'(BytesSent), 32'd0);
      base = re_count; bad = 0;
      repeat (3) begin
        @(negedge ReadClock);
        if ({ReadEnable, TxD, Busy} !== 3'b010) bad++;
      end
      check("reset beats start", 32'(bad + re_count - base), 32'd0);
      Reset = 1'b0;
      send_byte("post reset", 8'hC3, 10'h386, 8'h00, 1'b0, -1, 16'd1);
      check("post reset latency", 32'(last_wait), 32'd0);
    end

    // Counter wrap from 0xFFFF.
    @(negedge ReadClock);
    force dut.bytes_sent = 16'hFFFF;
    @(negedge ReadClock);
    release dut.bytes_sent;
    @(negedge ReadClock);
    check("preload count", 32'(BytesSent), 32'hFFFF);
    send_byte("wrap", 8'h01, 10'h202, 8'h00, 1'b0, -1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
